// File: rtl/sar_search.sv
// Successive-approximation search engine: drives trial into a combinational
// magnitude comparator and reconstructs the comparator's hidden operand from gt/lt/eq.
module sar_search #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err,
    output logic [CNT_W-1:0] compares
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_SEARCH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] trial_upd;
    logic [KW-1:0]    k_m1;
    logic             one_hot;

    assign k_m1    = k_q - 1'b1;
    assign one_hot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                     ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                     ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        exact_d   = exact_q;
        err_d     = err_q;
        done_d    = 1'b0;
        trial_upd = trial_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEARCH;
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    k_d     = KW'(WIDTH - 1);
                    cnt_d   = '0;
                    exact_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_SEARCH: begin
                cnt_d = cnt_q + 1'b1;
                // Decide bit k from the flags, then probe the next lower bit.
                if (cmp_gt) begin
                    trial_upd[k_q] = 1'b0;
                end
                if (k_q != '0) begin
                    trial_upd[k_m1] = 1'b1;
                end
                if (!one_hot) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end else if (cmp_eq) begin
                    result_d = trial_q;
                    exact_d  = 1'b1;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end else if (k_q != '0) begin
                    trial_d = trial_upd;
                    k_d     = k_m1;
                end else begin
                    trial_d  = trial_upd;
                    result_d = trial_upd;
                    exact_d  = 1'b0;
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            exact_q  <= exact_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign trial    = trial_q;
    assign busy     = (state_q == S_SEARCH);
    assign done     = done_q;
    assign result   = result_q;
    assign exact    = exact_q;
    assign err      = err_q;
    assign compares = cnt_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural comparator closes the loop,
// expected outcomes are queued at launch and checked by a monitor on done.
module tb_sar_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cmp_gt, cmp_lt, cmp_eq;
    logic [15:0] trial, result;
    logic        busy, done, exact, err;
    logic [4:0]  compares;

    logic [15:0] target = 16'h0000;
    logic        ovr_en = 1'b0;
    logic [2:0]  ovr_flags = 3'b000;   // {gt, lt, eq}

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        ex;
        logic        er;
        logic [4:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] trial_q[$];

    sar_search #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .trial(trial), .busy(busy), .done(done), .result(result),
        .exact(exact), .err(err), .compares(compares)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (ovr_en) begin
            {cmp_gt, cmp_lt, cmp_eq} = ovr_flags;
        end else begin
            cmp_gt = (trial > target);
            cmp_lt = (trial < target);
            cmp_eq = (trial == target);
        end
    end

    // Monitor: checks trial sequence while busy and the outcome on done.
    always @(negedge clk) begin
        if (busy && trial_q.size() > 0) begin
            logic [15:0] et;
            et = trial_q.pop_front();
            checks++;
            if (trial !== et) begin
                errors++;
                $display("FAIL trial_seq: got %h want %h", trial, et);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result=%h err=%b", result, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks += 4;
                if (result !== e.res) begin errors++; $display("FAIL result: got %h want %h", result, e.res); end
                if (exact !== e.ex)   begin errors++; $display("FAIL exact: got %b want %b", exact, e.ex); end
                if (err !== e.er)     begin errors++; $display("FAIL err: got %b want %b", err, e.er); end
                if (compares !== e.cnt) begin errors++; $display("FAIL compares: got %0d want %0d", compares, e.cnt); end
                $display("txn target=%h result=%h exact=%b err=%b compares=%0d", target, result, exact, err, compares);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic launch(input logic [15:0] tgt, input logic [15:0] r, input logic ex,
                          input logic er, input logic [4:0] cnt);
        target = tgt;
        exp_q.push_back('{res: r, ex: ex, er: er, cnt: cnt});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Steps compare cycles until done; optional flag override at compare force_at
    // and a stray start pulse at compare 4.
    task automatic wait_done(input int force_at, input logic [2:0] flags, input bit poke);
        bit seen;
        seen = 1'b0;
        for (int j = 1; j <= 20 && !seen; j++) begin
            ovr_en    = (j == force_at);
            ovr_flags = flags;
            start     = poke && (j == 4);
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        ovr_en = 1'b0;
        start  = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout: no done within 20 cycles");
        end
    endtask

    task automatic load_1234_trials();
        logic [15:0] seq [14];
        seq = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h1800, 16'h1400, 16'h1200,
                16'h1300, 16'h1280, 16'h1240, 16'h1220, 16'h1230, 16'h1238, 16'h1234};
        for (int i = 0; i < 14; i++) trial_q.push_back(seq[i]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_trial", 32'(trial), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", 32'({exact, err}), 32'h0);
        check("rst_compares", 32'(compares), 32'h0);

        launch(16'h8000, 16'h8000, 1'b1, 1'b0, 5'd1);
        check("busy_after_start", 32'(busy), 32'h1);
        check("first_trial", 32'(trial), 32'h8000);
        wait_done(0, 3'b000, 1'b0);
        check("busy_after_done", 32'(busy), 32'h0);
        @(posedge clk); #1;

        launch(16'h0000, 16'h0000, 1'b0, 1'b0, 5'd16);
        wait_done(0, 3'b000, 1'b0);
        @(posedge clk); #1;

        launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 5'd16);
        wait_done(0, 3'b000, 1'b0);
        @(posedge clk); #1;

        load_1234_trials();
        launch(16'h1234, 16'h1234, 1'b1, 1'b0, 5'd14);
        wait_done(0, 3'b000, 1'b0);
        @(posedge clk); #1;

        launch(16'h1234, 16'h0000, 1'b0, 1'b1, 5'd3);
        wait_done(3, 3'b110, 1'b0);
        @(posedge clk); #1;

        launch(16'h1234, 16'h0000, 1'b0, 1'b1, 5'd3);
        wait_done(3, 3'b000, 1'b0);
        @(posedge clk); #1;

        // Stray start mid-search must not perturb the trial sequence.
        load_1234_trials();
        launch(16'h1234, 16'h1234, 1'b1, 1'b0, 5'd14);
        wait_done(0, 3'b000, 1'b1);
        @(posedge clk); #1;

        // Reset on the 5th search cycle: no outcome queued, no done expected.
        target = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_trial", 32'(trial), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_compares", 32'(compares), 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_idle", 32'({busy, done}), 32'h0);

        // Back-to-back: second start issued during the done cycle.
        launch(16'h00FF, 16'h00FF, 1'b1, 1'b0, 5'd16);
        wait_done(0, 3'b000, 1'b0);
        launch(16'h8000, 16'h8000, 1'b1, 1'b0, 5'd1);
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_trial", 32'(trial), 32'h8000);
        wait_done(0, 3'b000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        check("trial_queue_empty", 32'(trial_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation search engine that drives the operand side of a 16-bit magnitude comparator and consumes its gt/lt/eq flags to recover the comparator's hidden second operand in at most WIDTH compare cycles. It owns one comparator input (`trial`, wired to the comparator's `a`). The other comparator input (`b`) is the unknown target. The block finishes early on an `eq` hit, flags malformed flag combinations, and reports the recovered value plus the number of compares used. It sits beside the existing combinational comparator and forms the initiator end of that gt/lt/eq interface.

## Interface
- WIDTH, 16, operand width (must be ≥2)
- CNT_W, 5, width of compare counter (must hold WIDTH)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin search; sampled only in IDLE
- cmp_gt  in  1  comparator flag, trial > target
- cmp_lt  in  1  comparator flag, trial < target
- cmp_eq  in  1  comparator flag, trial == target
- trial  out  WIDTH  registered candidate driven to comparator `a`
- busy  out  1  high while in SEARCH
- done  out  1  one-cycle pulse when a search ends (success or error)
- result  out  WIDTH  recovered target, held until next accepted start
- exact  out  1  an eq flag terminated the search; held with result
- err  out  1  flags not one-hot during search; held with result
- compares  out  CNT_W  number of compares consumed by last search; held

## Operation
- States: IDLE, SEARCH. `done` is a registered pulse asserted on the cycle the block re-enters IDLE.
- IDLE with `start`=1 → SEARCH:
  - trial = 1<<(WIDTH-1)
  - bit index k = WIDTH-1
  - compares = 0
  - exact = err = 0
  - result unchanged
- SEARCH cycle: comparator is combinational, so the flags are sampled on the same cycle `trial` is presented. compares += 1. Then:
  - flags not exactly one-hot (none or more than one set) → result = 0, err = 1, go IDLE, done.
  - cmp_eq → result = trial, exact = 1, go IDLE, done.
  - cmp_gt → clear bit k of trial.
  - cmp_lt → keep bit k of trial.
  - If k > 0 (and not eq/err): set bit k-1, k -= 1, stay in SEARCH.
  - If k == 0 (and not eq/err): result = updated trial, exact = 0, go IDLE, done.
- `start` while in SEARCH is ignored; no restart, no queuing.
- `trial` holds its last value in IDLE.
- Flags are ignored in IDLE.
- Width rules:
  - unsigned compare throughout
  - compares saturates never (max WIDTH ≤ 2^CNT_W-1)
  - trial bits below k are always 0 when presented

## Timing
- Reset values:
  - state IDLE
  - trial 0, result 0
  - busy 0, done 0, exact 0, err 0
  - compares 0
- Reset mid-search: next edge returns to IDLE with all reset values. No done pulse.
- Latency: start sampled at edge N. First trial is valid after edge N. busy is high from N. Compare j is sampled at edge N+j.
- Termination:
  - done, result, exact, err and compares update together at the terminating edge N+j. This is 1 ≤ j ≤ WIDTH.
  - busy falls at the same edge.
- Back-to-back operation: start may be asserted during the done cycle. It is accepted (state is IDLE), giving one idle cycle between searches minimum. The done cycle doubles as the accept cycle.

## Test plan
- Target 0x8000, start → first compare eq. done after 1 compare. result=0x8000, exact=1, compares=1, err=0.
- Target 0x0000 → trials 0x8000, 0x4000, …, 0x0001 all gt. result=0x0000, exact=0, compares=16.
- Target 0xFFFF → trials 0x8000, 0xC000, …, 0xFFFF. The 16th compare is eq. result=0xFFFF, exact=1, compares=16.
- Target 0x1234 → result=0x1234 and compares ≤ 16. Also check trial sequence starts 0x8000, 0x4000, 0x2000, 0x1000, 0x1800.
- Error and ignored-start cases:
  - Force cmp_gt=cmp_lt=1 on the 3rd compare → done, err=1, result=0, compares=3.
  - Same with all flags 0 → err=1.
  - start pulsed during SEARCH → no effect on the trial sequence.
- Reset and back-to-back cases:
  - Assert rst on the 5th SEARCH cycle → next cycle IDLE, trial=0, busy=0, no done pulse.
  - Start again with target 0x00FF → result 0x00FF. Issue start during the done cycle → accepted immediately.
